// File: rtl/ps2_lcd_pkg.sv
// Shared types and constants for the PS/2 keyboard to HD44780 text path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ps2_lcd_pkg;

    typedef enum logic [1:0] {
        OP_CHAR,
        OP_NEWLINE,
        OP_BKSP,
        OP_CLEAR
    } op_t;

    typedef enum logic [2:0] {
        ST_OFF,
        ST_INIT,
        ST_READY,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD
    } lcd_state_t;

    // One queued keyboard operation
    typedef struct packed {
        op_t        op;
        logic [7:0] dat;
    } fifo_ent_t;

    // One LCD bus write: register select plus byte
    typedef struct packed {
        logic       rs;
        logic [7:0] dat;
    } lcd_wr_t;

    // Scan-code set 2 prefixes and special keys
    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_ENTER  = 8'h5A;
    localparam logic [7:0] SC_BKSP   = 8'h66;
    localparam logic [7:0] SC_ESC    = 8'h76;
    localparam logic [7:0] SC_SPACE  = 8'h29;

    // HD44780 commands
    localparam logic [7:0] LCD_FUNC_SET = 8'h38;
    localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
    localparam logic [7:0] LCD_CLEAR    = 8'h01;
    localparam logic [7:0] LCD_ENTRY    = 8'h06;
    localparam logic [7:0] LCD_SET_ADDR = 8'h80;

endpackage

// File: rtl/ps2_scan_decoder.sv
// Tracks break/extended prefixes and shift state, turns make codes into ops.
// Latency: 1 cycle from ps2_code_new to push.
// Backpressure: none; consumer must accept or drop every push.
module ps2_scan_decoder
    import ps2_lcd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] ps2_code,
    input  logic       ps2_code_new,
    output logic       push,
    output op_t        op,
    output logic [7:0] data
);

    logic       brk_pend;
    logic       ext_pend;
    logic       shift;
    logic       is_shift;
    logic       map_vld;
    logic       is_let;
    logic [7:0] lc;
    logic [7:0] map_asc;

    assign is_shift = (ps2_code == SC_LSHIFT) || (ps2_code == SC_RSHIFT);

    // Scan code to ASCII; letters share one entry and are upper-cased by shift
    always_comb begin
        map_vld = 1'b1;
        is_let  = 1'b1;
        lc      = 8'h00;
        map_asc = 8'h00;
        case (ps2_code)
            8'h1C: lc = 8'h61; 8'h32: lc = 8'h62; 8'h21: lc = 8'h63; 8'h23: lc = 8'h64;
            8'h24: lc = 8'h65; 8'h2B: lc = 8'h66; 8'h34: lc = 8'h67; 8'h33: lc = 8'h68;
            8'h43: lc = 8'h69; 8'h3B: lc = 8'h6A; 8'h42: lc = 8'h6B; 8'h4B: lc = 8'h6C;
            8'h3A: lc = 8'h6D; 8'h31: lc = 8'h6E; 8'h44: lc = 8'h6F; 8'h4D: lc = 8'h70;
            8'h15: lc = 8'h71; 8'h2D: lc = 8'h72; 8'h1B: lc = 8'h73; 8'h2C: lc = 8'h74;
            8'h3C: lc = 8'h75; 8'h2A: lc = 8'h76; 8'h1D: lc = 8'h77; 8'h22: lc = 8'h78;
            8'h35: lc = 8'h79; 8'h1A: lc = 8'h7A;
            8'h16: begin is_let = 1'b0; map_asc = shift ? 8'h21 : 8'h31; end
            8'h1E: begin is_let = 1'b0; map_asc = shift ? 8'h40 : 8'h32; end
            8'h26: begin is_let = 1'b0; map_asc = shift ? 8'h23 : 8'h33; end
            8'h25: begin is_let = 1'b0; map_asc = shift ? 8'h24 : 8'h34; end
            8'h2E: begin is_let = 1'b0; map_asc = shift ? 8'h25 : 8'h35; end
            8'h36: begin is_let = 1'b0; map_asc = shift ? 8'h5E : 8'h36; end
            8'h3D: begin is_let = 1'b0; map_asc = shift ? 8'h26 : 8'h37; end
            8'h3E: begin is_let = 1'b0; map_asc = shift ? 8'h2A : 8'h38; end
            8'h46: begin is_let = 1'b0; map_asc = shift ? 8'h28 : 8'h39; end
            8'h45: begin is_let = 1'b0; map_asc = shift ? 8'h29 : 8'h30; end
            SC_SPACE: begin is_let = 1'b0; map_asc = 8'h20; end
            default: begin is_let = 1'b0; map_vld = 1'b0; end
        endcase
        if (is_let) begin
            map_asc = shift ? (lc - 8'h20) : lc;
        end
    end

    // Prefix/shift tracking and registered op output
    always_ff @(posedge clk) begin
        if (rst) begin
            brk_pend <= 1'b0;
            ext_pend <= 1'b0;
            shift    <= 1'b0;
            push     <= 1'b0;
            op       <= OP_CHAR;
            data     <= 8'h00;
        end else begin
            push <= 1'b0;
            if (ps2_code_new) begin
                if (ps2_code == SC_BREAK) begin
                    brk_pend <= 1'b1;
                end else if (ps2_code == SC_EXT) begin
                    ext_pend <= 1'b1;
                end else begin
                    brk_pend <= 1'b0;
                    ext_pend <= 1'b0;
                    if (brk_pend) begin
                        if (is_shift) shift <= 1'b0;
                    end else if (!ext_pend) begin
                        if (is_shift) begin
                            shift <= 1'b1;
                        end else if (ps2_code == SC_ENTER) begin
                            push <= 1'b1; op <= OP_NEWLINE; data <= 8'h00;
                        end else if (ps2_code == SC_BKSP) begin
                            push <= 1'b1; op <= OP_BKSP; data <= 8'h00;
                        end else if (ps2_code == SC_ESC) begin
                            push <= 1'b1; op <= OP_CLEAR; data <= 8'h00;
                        end else if (map_vld) begin
                            push <= 1'b1; op <= OP_CHAR; data <= map_asc;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: rtl/ps2_lcd_text_ctrl.sv
// PS/2 keystrokes to multi-row HD44780 text: decode, op FIFO, LCD bus sequencer.
// Latency: decode 1 cycle, FIFO 1 cycle, then SETUP + EN_CYC + hold per bus write.
// Backpressure: none upstream; ops pushed into a full FIFO are dropped and flagged sticky.
module ps2_lcd_text_ctrl
    import ps2_lcd_pkg::*;
#(
    parameter int COLS         = 16,
    parameter int ROWS         = 2,
    parameter int FIFO_DEPTH   = 8,
    parameter int EN_CYC       = 12,
    parameter int CMD_WAIT_CYC = 2000,
    parameter int CLR_WAIT_CYC = 82000
)(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          go,
    input  logic [7:0]                    ps2_code,
    input  logic                          ps2_code_new,
    output logic [7:0]                    lcd_data,
    output logic                          lcd_en,
    output logic                          lcd_rs,
    output logic                          lcd_rw,
    output logic                          lcd_on,
    output logic [$clog2(COLS*ROWS)-1:0]  pointer,
    output logic                          fifo_full,
    output logic                          overflow,
    output logic                          busy
);

    localparam int TOTAL = COLS * ROWS;
    localparam int PW    = $clog2(TOTAL);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int TW    = $clog2(((CLR_WAIT_CYC > CMD_WAIT_CYC) ? CLR_WAIT_CYC : CMD_WAIT_CYC) + EN_CYC + 1);

    // Set-DDRAM-address command for a linear cursor index
    function automatic logic [7:0] set_addr(input logic [PW-1:0] p);
        int         r;
        int         c;
        logic [7:0] base;
        r = int'(p) / COLS;
        c = int'(p) % COLS;
        case (r)
            1:       base = 8'h40;
            2:       base = 8'(COLS);
            3:       base = 8'(64 + COLS);
            default: base = 8'h00;
        endcase
        return LCD_SET_ADDR | (base + 8'(c));
    endfunction

    logic       dec_push;
    op_t        dec_op;
    logic [7:0] dec_dat;

    ps2_scan_decoder u_dec (
        .clk          (clk),
        .rst          (rst),
        .ps2_code     (ps2_code),
        .ps2_code_new (ps2_code_new),
        .push         (dec_push),
        .op           (dec_op),
        .data         (dec_dat)
    );

    // ---------------- op FIFO ----------------
    fifo_ent_t fifo_mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr, fifo_cnt;
    logic        fifo_empty, wr_en, pop;
    fifo_ent_t   head;

    assign fifo_cnt   = wr_ptr - rd_ptr;
    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_full  = (fifo_cnt == (AW+1)'(FIFO_DEPTH));
    assign wr_en      = dec_push && (!fifo_full || pop);
    assign head       = fifo_mem[rd_ptr[AW-1:0]];

    // FIFO storage; contents are don't-care while empty
    always_ff @(posedge clk) begin
        if (wr_en) fifo_mem[wr_ptr[AW-1:0]] <= '{op: dec_op, dat: dec_dat};
    end

    // FIFO pointers and sticky drop flag
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            if (dec_push && fifo_full && !pop) overflow <= 1'b1;
        end
    end

    // ---------------- op sequencer ----------------
    lcd_state_t    state, state_nxt;
    lcd_wr_t       plan [4];
    lcd_wr_t       seq  [4];
    logic [2:0]    plan_cnt, seq_cnt;
    logic [1:0]    seq_idx;
    logic [PW-1:0] plan_ptr, seq_ptr, ptr_inc, ptr_dec, ptr_nl;
    logic [TW-1:0] tmr, hold_last;
    lcd_wr_t       cur_wr;
    logic          last_wr, load_op, load_init, tmr_clr, idx_inc, ptr_upd, in_wr;

    assign ptr_inc   = (pointer == PW'(TOTAL - 1)) ? '0 : pointer + 1'b1;
    assign ptr_dec   = pointer - 1'b1;
    assign ptr_nl    = ((int'(pointer) / COLS) == ROWS - 1) ? '0 : PW'(((int'(pointer) / COLS) + 1) * COLS);
    assign cur_wr    = seq[seq_idx];
    assign hold_last = (!cur_wr.rs && cur_wr.dat == LCD_CLEAR) ? TW'(CLR_WAIT_CYC - 1) : TW'(CMD_WAIT_CYC - 1);
    assign last_wr   = ({1'b0, seq_idx} == (seq_cnt - 3'd1));

    // Expand the FIFO head op into its list of bus writes and resulting cursor
    always_comb begin
        for (int i = 0; i < 4; i++) plan[i] = '0;
        plan_cnt = 3'd0;
        plan_ptr = pointer;
        case (head.op)
            OP_CHAR: begin
                if ((int'(pointer) % COLS) == 0) begin
                    plan[0]  = '{rs: 1'b0, dat: set_addr(pointer)};
                    plan[1]  = '{rs: 1'b1, dat: head.dat};
                    plan_cnt = 3'd2;
                end else begin
                    plan[0]  = '{rs: 1'b1, dat: head.dat};
                    plan_cnt = 3'd1;
                end
                plan_ptr = ptr_inc;
            end
            OP_NEWLINE: begin
                plan[0]  = '{rs: 1'b0, dat: set_addr(ptr_nl)};
                plan_cnt = 3'd1;
                plan_ptr = ptr_nl;
            end
            OP_BKSP: begin
                if (pointer != '0) begin
                    plan[0]  = '{rs: 1'b0, dat: set_addr(ptr_dec)};
                    plan[1]  = '{rs: 1'b1, dat: 8'h20};
                    plan[2]  = '{rs: 1'b0, dat: set_addr(ptr_dec)};
                    plan_cnt = 3'd3;
                    plan_ptr = ptr_dec;
                end
            end
            default: begin
                plan[0]  = '{rs: 1'b0, dat: LCD_CLEAR};
                plan_cnt = 3'd1;
                plan_ptr = '0;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= ST_OFF;
        else     state <= state_nxt;
    end

    // FSM next state, sequencer controls and LCD pin outputs
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        load_op   = 1'b0;
        load_init = 1'b0;
        tmr_clr   = 1'b0;
        idx_inc   = 1'b0;
        ptr_upd   = 1'b0;
        case (state)
            ST_OFF:   if (go) state_nxt = ST_INIT;
            ST_INIT: begin
                load_init = 1'b1;
                state_nxt = ST_SETUP;
            end
            ST_READY: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    load_op = 1'b1;
                    if (plan_cnt != 3'd0) state_nxt = ST_SETUP;
                end
            end
            ST_SETUP: begin
                tmr_clr   = 1'b1;
                state_nxt = ST_PULSE;
            end
            ST_PULSE: begin
                if (tmr == TW'(EN_CYC - 1)) begin
                    tmr_clr   = 1'b1;
                    state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (tmr == hold_last) begin
                    if (last_wr) begin
                        ptr_upd   = 1'b1;
                        state_nxt = ST_READY;
                    end else begin
                        idx_inc   = 1'b1;
                        state_nxt = ST_SETUP;
                    end
                end
            end
            default: state_nxt = ST_OFF;
        endcase
        in_wr    = (state == ST_SETUP) || (state == ST_PULSE) || (state == ST_HOLD);
        lcd_data = in_wr ? cur_wr.dat : 8'h00;
        lcd_rs   = in_wr ? cur_wr.rs  : 1'b0;
        lcd_en   = (state == ST_PULSE);
        lcd_rw   = 1'b0;
        lcd_on   = (state != ST_OFF);
        busy     = (state != ST_READY) || !fifo_empty;
    end

    // Sequencer datapath: write list, index, timer and cursor
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) seq[i] <= '0;
            seq_cnt <= 3'd0;
            seq_idx <= 2'd0;
            seq_ptr <= '0;
            tmr     <= '0;
            pointer <= '0;
        end else begin
            tmr <= tmr_clr ? '0 : tmr + 1'b1;
            if (load_init) begin
                seq[0]  <= '{rs: 1'b0, dat: LCD_FUNC_SET};
                seq[1]  <= '{rs: 1'b0, dat: LCD_DISP_ON};
                seq[2]  <= '{rs: 1'b0, dat: LCD_CLEAR};
                seq[3]  <= '{rs: 1'b0, dat: LCD_ENTRY};
                seq_cnt <= 3'd4;
                seq_idx <= 2'd0;
                seq_ptr <= '0;
            end else if (load_op) begin
                seq     <= plan;
                seq_cnt <= plan_cnt;
                seq_idx <= 2'd0;
                seq_ptr <= plan_ptr;
            end else if (idx_inc) begin
                seq_idx <= seq_idx + 2'd1;
            end
            if (ptr_upd) pointer <= seq_ptr;
        end
    end

endmodule

// File: doc/ps2_lcd_text_ctrl.md
Name: ps2_lcd_text_ctrl

Overview:
Parametrised successor to the single-line PS/2-to-LCD path. Consumes PS/2 scan codes from the existing PS/2 receiver and decodes make/break/extended prefixes and shift state. Queues decoded ops in a FIFO and drives an HD44780-style 8-bit LCD bus: power-up init, multi-row cursor, newline, backspace and clear. Sits between the PS/2 receiver and the LCD pins in the board top level.

Parameters:
COLS, 16, characters per LCD row (8..40)
ROWS, 2, LCD rows; legal values 1, 2, 4
FIFO_DEPTH, 8, op FIFO entries (power of 2, >=2)
EN_CYC, 12, clk cycles lcd_en held high per write
CMD_WAIT_CYC, 2000, post-write wait for normal commands/data (40 us at 50 MHz)
CLR_WAIT_CYC, 82000, post-write wait for clear command 0x01 (1.64 ms)

Ports:
clk  in  1  system clock; sole clock
rst  in  1  synchronous, active-high reset
go  in  1  level; high while in OFF starts LCD init
ps2_code  in  8  scan code from PS/2 receiver
ps2_code_new  in  1  one-cycle strobe; ps2_code valid that cycle
lcd_data  out  8  LCD DB7..DB0
lcd_en  out  1  LCD enable strobe
lcd_rs  out  1  0 = command, 1 = data
lcd_rw  out  1  constant 0 (write only)
lcd_on  out  1  LCD power/backlight enable
pointer  out  $clog2(COLS*ROWS)  linear cursor index, 0..COLS*ROWS-1
fifo_full  out  1  FIFO at FIFO_DEPTH entries
overflow  out  1  sticky: an op was dropped because the FIFO was full
busy  out  1  high when not in READY or FIFO non-empty

Behaviour:
- Reset (any cycle, incl. mid-write): lcd_data=0, lcd_en=0, lcd_rs=0, lcd_rw=0, lcd_on=0, pointer=0, overflow=0, FIFO emptied, shift/break/ext flags cleared, FSM=OFF, busy=1. A new go is required after reset.
- Decoder, one code per ps2_code_new:
  - 0xF0 sets break_pending.
  - 0xE0 sets ext_pending.
  - The next code consumes and clears both flags.
  - Break of 0x12/0x59 clears shift; every other break is ignored.
  - Make 0x12/0x59 sets shift; ext codes are ignored.
  - Make codes for letters, digits and space (0x29) map to ASCII; shift selects upper case / symbol set.
  - 0x5A pushes NEWLINE, 0x66 pushes BKSP, 0x76 (Esc) pushes CLEAR; unmapped codes are dropped.
  - Decode-to-push latency is 1 cycle.
- FIFO entry = {op[1:0], data[7:0]}, op ∈ CHAR/NEWLINE/BKSP/CLEAR.
  - Push while full with no pop that cycle: dropped, overflow<=1.
  - Push and pop in the same cycle while full: both accepted.
  - Pushes are accepted in every FSM state, including OFF.
- FSM states: OFF, INIT, READY, SETUP, PULSE, HOLD, plus op sequencer.
  - OFF: lcd_on=0. go=1 moves to INIT, with lcd_on=1 from the next cycle. go in any other state is ignored.
  - INIT issues commands 0x38, 0x0C, 0x01, 0x06 (rs=0), then enters READY with pointer=0.
  - Each bus write:
    - SETUP: 1 cycle; data/rs driven, en=0.
    - PULSE: EN_CYC cycles, en=1.
    - HOLD: en=0 for CMD_WAIT_CYC, or CLR_WAIT_CYC when the command is 0x01.
    - lcd_data and lcd_rs stay stable from SETUP through the end of HOLD.
  - READY pops one entry when the FIFO is non-empty; the pop is registered.
- Row base addresses: row0 0x00, row1 0x40, row2 COLS, row3 0x40+COLS. Set-address command = 0x80|(base+col).
- Op sequences:
  - CHAR: if col==0, issue set-address first. Write data (rs=1). pointer+1, wrapping COLS*ROWS-1 → 0.
  - NEWLINE: pointer = start of next row (last row wraps to 0), then issue set-address.
  - BKSP: at pointer==0 it is a no-op (no bus writes). Otherwise pointer-1, set-address, write 0x20, set-address again.
  - CLEAR: write command 0x01 with CLR_WAIT_CYC hold; pointer=0.
- pointer updates in the cycle the op's final HOLD ends.

Decomposition:
- Package ps2_lcd_pkg:
  - op_t enum (CHAR, NEWLINE, BKSP, CLEAR).
  - scan-code constants (0xF0, 0xE0, 0x12, 0x59, 0x5A, 0x66, 0x76, 0x29).
  - LCD command constants (0x38, 0x0C, 0x01, 0x06, 0x80).
  - lcd_state_t enum.
- Sub-module ps2_scan_decoder: prefix/shift tracking plus ASCII table; outputs op, data and a push strobe. FIFO and LCD FSM stay in the top.

Test Plan:
- rst, then go=1 with FIFO empty → bus writes 0x38, 0x0C, 0x01, 0x06 (rs=0); 0x01 holds 82000 cycles; READY with pointer=0.
- Codes 0x1C, 0xF0, 0x1C ('a' press/release) → set-address 0x80, data 0x61 (rs=1); pointer=1; the break produces no write.
- 0x12, 0x1C, 0xF0, 0x12, 0x1C → data 0x41 then 0x61 (shift applied then released).
- 17 'a' codes with COLS=16, ROWS=2 → 17th write preceded by 0xC0; pointer=17. After 32 chars pointer wraps to 0 and the next char is preceded by 0x80.
- 0x66 at pointer=0 → no bus activity. At pointer=5 → writes 0x84, 0x20, 0x84; pointer=4.
- Before go, push FIFO_DEPTH+1 mapped codes → fifo_full=1, overflow=1. After go and init, exactly FIFO_DEPTH chars are written; overflow stays 1 until rst. rst asserted mid-PULSE → lcd_en=0 and lcd_on=0 next cycle.
